// File: rtl/data_mem_store_buffer_if.sv
// Data-memory stage bus between the M stage and the store-buffered RAM.
// The processor side is the master; the memory block is the slave.
interface data_mem_store_buffer_if;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        stall;
   logic        sb_empty;

   modport master (
      output mem_write,
      output mem_read,
      output addr,
      output write_data,
      input  read_data,
      input  stall,
      input  sb_empty
   );

   modport slave (
      input  mem_write,
      input  mem_read,
      input  addr,
      input  write_data,
      output read_data,
      output stall,
      output sb_empty
   );
endinterface

// File: rtl/data_mem_store_buffer.sv
// Word RAM behind a posted-store FIFO; stores drain in load-free cycles
// and loads forward the youngest matching buffered store.
module data_mem_store_buffer #(
   parameter int ADDR_W   = 8,
   parameter int SB_DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   data_mem_store_buffer_if.slave bus
);

   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(SB_DEPTH);

   logic [31:0]       ram     [2**ADDR_W];
   logic [ADDR_W-1:0] sb_idx  [SB_DEPTH];
   logic [31:0]       sb_data [SB_DEPTH];

   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;

   logic [ADDR_W-1:0] idx;
   logic              enq;
   logic              deq;
   logic              hit;
   logic [31:0]       fwd_data;
   logic              unused_addr;

   // Byte offset and high bits are dropped, so addresses alias.
   assign idx         = bus.addr[ADDR_W+1:2];
   assign unused_addr = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

   assign bus.stall    = bus.mem_write && (count == FULL);
   assign bus.sb_empty = (count == '0);

   assign enq = bus.mem_write && !bus.stall;
   assign deq = (count != '0) && !bus.mem_read;

   // Scan oldest to youngest so the last hit is the youngest store.
   always_comb begin
      logic [PW-1:0] pos;
      pos      = '0;
      hit      = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         pos = head + PW'(i);
         if ((CW'(i) < count) && (sb_idx[pos] == idx)) begin
            hit      = 1'b1;
            fwd_data = sb_data[pos];
         end
      end
   end

   assign bus.read_data = hit ? fwd_data : ram[idx];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PW'(1);
         if (deq) head <= head + PW'(1);
         count <= count + CW'(enq) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         sb_idx[tail]  <= idx;
         sb_data[tail] <= bus.write_data;
      end
   end

   // RAM keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (deq) ram[sb_idx[head]] <= sb_data[head];
   end

endmodule

// File: tb/tb_data_mem_store_buffer.sv
// Directed vector bench for data_mem_store_buffer: per-cycle table
// plus a hand sequence for reset during a drain.
module tb_data_mem_store_buffer;

   logic clk;
   logic reset;

   data_mem_store_buffer_if bus ();

   data_mem_store_buffer #(
      .ADDR_W   (8),
      .SB_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic        r;
      logic [31:0] a;
      logic [31:0] d;
      logic        chk_rd;
      logic [31:0] rd;
      logic        stall;
      logic        empty;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add_v(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic chk_rd, input logic [31:0] rd,
                        input logic stall, input logic empty);
      vec_t v;
      v.w = w; v.r = r; v.a = a; v.d = d;
      v.chk_rd = chk_rd; v.rd = rd;
      v.stall = stall; v.empty = empty;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d);
      bus.mem_write  = w;
      bus.mem_read   = r;
      bus.addr       = a;
      bus.write_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // basic store, drain, load
      add_v(1, 0, 32'h10, 32'h1111_1111, 0, 0, 0, 1);
      add_v(0, 0, 32'h10, 0, 1, 32'h1111_1111, 0, 0);
      add_v(0, 1, 32'h10, 0, 1, 32'h1111_1111, 0, 1);
      // fill the buffer under held reads
      add_v(1, 1, 32'h00, 32'hA0, 0, 0, 0, 1);
      add_v(1, 1, 32'h04, 32'hA1, 0, 0, 0, 0);
      add_v(1, 1, 32'h08, 32'hA2, 0, 0, 0, 0);
      add_v(1, 1, 32'h0C, 32'hA3, 0, 0, 0, 0);
      add_v(1, 0, 32'h20, 32'hA4, 0, 0, 1, 0);
      add_v(1, 0, 32'h20, 32'hA4, 0, 0, 0, 0);
      add_v(0, 1, 32'h20, 0, 1, 32'hA4, 0, 0);
      add_v(0, 1, 32'h00, 0, 1, 32'hA0, 0, 0);
      add_v(0, 1, 32'h08, 0, 1, 32'hA2, 0, 0);
      add_v(0, 1, 32'h0C, 0, 1, 32'hA3, 0, 0);
      add_v(0, 0, 32'h04, 0, 1, 32'hA1, 0, 0);
      add_v(0, 0, 32'h04, 0, 1, 32'hA1, 0, 0);
      add_v(0, 0, 32'h04, 0, 1, 32'hA1, 0, 0);
      add_v(0, 1, 32'h20, 0, 1, 32'hA4, 0, 1);
      // two stores to one word, youngest wins
      add_v(1, 0, 32'h08, 32'h5, 0, 0, 0, 1);
      add_v(1, 0, 32'h08, 32'h6, 1, 32'h5, 0, 0);
      add_v(0, 1, 32'h08, 0, 1, 32'h6, 0, 0);
      add_v(0, 1, 32'h08, 0, 1, 32'h6, 0, 0);
      add_v(0, 0, 32'h08, 0, 1, 32'h6, 0, 0);
      add_v(0, 1, 32'h08, 0, 1, 32'h6, 0, 1);
      // aliasing
      add_v(1, 0, 32'h400, 32'hDEAD_BEEF, 0, 0, 0, 1);
      add_v(0, 1, 32'h000, 0, 1, 32'hDEAD_BEEF, 0, 0);
      add_v(0, 1, 32'h403, 0, 1, 32'hDEAD_BEEF, 0, 0);
      add_v(0, 0, 32'h000, 0, 1, 32'hDEAD_BEEF, 0, 0);
      add_v(0, 1, 32'h403, 0, 1, 32'hDEAD_BEEF, 0, 1);
      // held loads suppress draining
      add_v(1, 1, 32'h30, 32'hC0, 0, 0, 0, 1);
      add_v(1, 1, 32'h34, 32'hC1, 0, 0, 0, 0);
      add_v(0, 1, 32'h30, 0, 1, 32'hC0, 0, 0);
      add_v(0, 1, 32'h30, 0, 1, 32'hC0, 0, 0);
      add_v(0, 1, 32'h30, 0, 1, 32'hC0, 0, 0);
      add_v(0, 0, 32'h34, 0, 1, 32'hC1, 0, 0);
      add_v(0, 0, 32'h30, 0, 1, 32'hC0, 0, 0);
      add_v(0, 1, 32'h34, 0, 1, 32'hC1, 0, 1);
      // seed RAM words 20..22
      add_v(1, 0, 32'h50, 32'hE0, 0, 0, 0, 1);
      add_v(1, 0, 32'h54, 32'hE1, 0, 0, 0, 0);
      add_v(1, 0, 32'h58, 32'hE2, 0, 0, 0, 0);
      add_v(0, 0, 32'h58, 0, 1, 32'hE2, 0, 0);
      add_v(0, 1, 32'h54, 0, 1, 32'hE1, 0, 1);

      reset = 1'b0;
      drive(0, 0, 0, 0);
      #1;
      check("reset sb_empty", {31'd0, bus.sb_empty}, 32'd1);
      check("reset stall", {31'd0, bus.stall}, 32'd0);
      #21;
      reset = 1'b1;
      tick();

      foreach (vecs[i]) begin
         drive(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d);
         #1;
         check($sformatf("v%0d stall", i),
               {31'd0, bus.stall}, {31'd0, vecs[i].stall});
         check($sformatf("v%0d sb_empty", i),
               {31'd0, bus.sb_empty}, {31'd0, vecs[i].empty});
         if (vecs[i].chk_rd)
            check($sformatf("v%0d read_data", i),
                  bus.read_data, vecs[i].rd);
         tick();
      end

      // three pending stores, reset lands during a drain cycle
      drive(1, 1, 32'h50, 32'hF0); tick();
      drive(1, 1, 32'h54, 32'hF1); tick();
      drive(1, 1, 32'h58, 32'hF2); #1;
      check("pend3 fwd", bus.read_data, 32'hE2);
      tick();
      drive(0, 1, 32'h54, 0); #1;
      check("pend3 fwd F1", bus.read_data, 32'hF1);
      tick();
      drive(0, 0, 32'h50, 0);
      #2;
      reset = 1'b0;
      bus.mem_write = 1'b1;
      #1;
      check("rst mid sb_empty", {31'd0, bus.sb_empty}, 32'd1);
      check("rst mid stall", {31'd0, bus.stall}, 32'd0);
      check("rst mid rd 50", bus.read_data, 32'hE0);
      bus.mem_write = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      tick();
      drive(0, 1, 32'h50, 0); #1;
      check("post rst rd 50", bus.read_data, 32'hE0);
      drive(0, 1, 32'h54, 0); #1;
      check("post rst rd 54", bus.read_data, 32'hE1);
      drive(0, 1, 32'h58, 0); #1;
      check("post rst rd 58", bus.read_data, 32'hE2);
      check("post rst sb_empty", {31'd0, bus.sb_empty}, 32'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_store_buffer.md
Name: data_mem_store_buffer

Overview:
- Data-memory stage directly downstream of the processor's memory-access stage.
- Takes the M-stage address (alu_out_M), store data (write_data_M) and mem_write.
- Returns read_data_M in the same cycle.
- Stores are posted into a small FIFO store buffer and drained into a single-write-port word RAM in cycles with no load; loads forward from the buffer so a load always sees the youngest value.

Parameters:
- ADDR_W, 8, word-index width; RAM holds 2**ADDR_W 32-bit words.
- SB_DEPTH, 4, store-buffer entries; power of two, >=2.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- mem_write  input  1  store request this cycle (from processor mem_write)
- mem_read  input  1  load request this cycle (processor mem_to_reg_M)
- addr  input  32  byte address (processor alu_out_M)
- write_data  input  32  store data (processor write_data_M)
- read_data  output  32  load data (processor read_data_M), combinational
- stall  output  1  store not accepted this cycle; pipeline must hold M stage
- sb_empty  output  1  store buffer holds no pending stores

Behaviour:
- Reset (reset=0, asynchronous):
  - head, tail and count cleared to 0; buffered entries discarded.
  - sb_empty=1 and stall=0.
  - RAM contents are not cleared.
  - Stores pending at reset assertion are lost.
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - addr[1:0] and addr[31:ADDR_W+2] are ignored, so addresses alias modulo 2**ADDR_W words.
- Store buffer:
  - FIFO of SB_DEPTH entries {index, data}.
  - head and tail pointers wrap modulo SB_DEPTH.
  - count ranges 0..SB_DEPTH.
- stall = mem_write && (count == SB_DEPTH), combinational.
- Enqueue: at a clock edge with mem_write=1 and stall=0, write {index, write_data} at tail and advance tail.
- Drain: at a clock edge with count>0 and mem_read=0, write head entry into RAM and advance head.
  - Drain is suppressed in any cycle with mem_read=1.
- Same-edge enqueue and drain: count unchanged; both pointers advance.
- Full and a store presented:
  - mem_write implies mem_read=0, so the head drains that edge and count becomes SB_DEPTH-1.
  - The held store is accepted on the next cycle, so stall lasts exactly one cycle.
- Simultaneous mem_read=1 and mem_write=1 is not produced by the processor. If it occurs:
  - the store enqueues as normal (subject to stall);
  - the load returns its value;
  - the drain is suppressed.
- Load path, combinational, zero latency: read_data is the data of the youngest valid buffer entry whose index matches.
  - Youngest means nearest to tail, scanning backwards from tail-1.
  - Only entries in positions head..tail-1 count as valid.
  - If no entry matches, read_data is RAM[index].
  - A store enqueued on the current edge is visible to a load in the next cycle, not the same cycle.
- read_data is driven from addr every cycle regardless of mem_read; the processor ignores it when not loading.
- sb_empty = (count == 0).
- Ordering: multiple stores to one index drain in program order, so the RAM ends with the last one.

Test Plan:
- Reset then store 0x1111_1111 to addr 0x10, then idle 1 cycle, then load 0x10 -> read_data=0x1111_1111; sb_empty=1 after the drain edge.
- With mem_read held 1 on addr 0x40: four stores (0xA0..0xA3 to addr 0x00,0x04,0x08,0x0C) presented on separate cycles between reads -> all four accepted, then count=4 and sb_empty=0. A fifth store to 0x20 -> stall=1 for exactly one cycle, accepted next cycle, none lost.
- Stores 0x5 then 0x6 to addr 0x08 back-to-back, then immediate load 0x08 with mem_read held 1 (no drain) -> read_data=0x6. After draining, RAM[2]=0x6.
- Alias check with ADDR_W=8: store 0xDEAD_BEEF to addr 0x0000_0400 -> load 0x0000_0000 returns 0xDEAD_BEEF. Load 0x0000_0403 returns the same value.
- Continuous loads (mem_read=1) with 2 entries pending -> count stays 2, no RAM writes. First cycle with mem_read=0 drains one entry per edge.
- Assert reset low mid-drain with 3 entries pending -> sb_empty=1 and stall=0 immediately. Undrained addresses read back pre-existing RAM values.
